// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a register window on the CPU data port feeds a small
// TX FIFO that a start/data/stop shifter drains.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        en,
   input  logic        wen,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        tx
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic          sel, push, push_ok, pop, baud_wr, stat_rd, full, empty, busy, bit_end;
   logic [3:0]    off;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [4:0]    count_q;
   logic          ovf_q;
   logic [15:0]   baud_q;
   logic [31:0]   rd_val, status;
   logic [31:0]   rdata_q;
   logic          hit_q;

   state_e        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_q, bit_d;
   logic [15:0]   cnt_q, cnt_d, div_q, div_d;
   logic          tx_q, tx_d;

   assign off     = addr[3:0];
   assign sel     = en && (addr[31:4] == BASE_ADDR[31:4]);
   assign push    = sel && wen && (off == 4'h0);
   assign baud_wr = sel && wen && (off == 4'h8);
   assign stat_rd = sel && !wen && (off == 4'h4);
   assign full    = (count_q == 5'(FIFO_DEPTH));
   assign empty   = (count_q == 5'd0);
   assign busy    = (state_q != StIdle);
   // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
   assign push_ok = push && (!full || pop);
   assign status  = {19'b0, count_q, 4'b0, ovf_q, busy, empty, full};

   always_comb begin
      rd_val = 32'b0;
      if (sel && !wen) begin
         case (off)
            4'h4:    rd_val = status;
            4'h8:    rd_val = {16'b0, baud_q};
            default: rd_val = 32'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 5'd0;
         ovf_q    <= 1'b0;
         baud_q   <= DEFAULT_DIV;
         rdata_q  <= 32'b0;
         hit_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop)      count_q <= count_q + 5'd1;
         else if (!push_ok && pop) count_q <= count_q - 5'd1;
         // Set wins over the read-to-clear.
         if (push && !push_ok) ovf_q <= 1'b1;
         else if (stat_rd)     ovf_q <= 1'b0;
         if (baud_wr) baud_q <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
         rdata_q <= rd_val;
         hit_q   <= sel && !wen;
      end
   end

   assign bit_end = (cnt_q == div_q - 16'd1);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               div_d   = baud_q;
               cnt_d   = 16'd0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               cnt_d   = 16'd0;
               bit_d   = 3'd0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d   = 16'd0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) state_d = StStop;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (bit_end) begin
               cnt_d = 16'd0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  div_d   = baud_q;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      // tx is registered from the next state so the line changes on the same edge as the FSM.
      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= 8'd0;
         bit_q   <= 3'd0;
         cnt_q   <= 16'd0;
         div_q   <= DEFAULT_DIV;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         tx_q    <= tx_d;
      end
   end

   assign rdata = rdata_q;
   assign hit   = hit_q;
   assign tx    = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame waveforms, overflow and reset cases.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;

   logic        clk, rst, en, wen;
   logic [31:0] addr, wdata, rdata;
   logic        hit, tx;

   int checks   = 0;
   int failures = 0;
   logic exp_q[$];

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (8),
      .DEFAULT_DIV(16'd434)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .wdata(wdata),
      .en   (en),
      .wen  (wen),
      .rdata(rdata),
      .hit  (hit),
      .tx   (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives a write that the next rising edge samples, without waiting for it.
   task automatic set_write(input logic [3:0] o, input logic [31:0] d);
      addr  = BASE | {28'b0, o};
      wdata = d;
      en    = 1'b1;
      wen   = 1'b1;
   endtask

   task automatic bus_write(input logic [3:0] o, input logic [31:0] d);
      set_write(o, d);
      @(posedge clk);
      #1;
      en  = 1'b0;
      wen = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a);
      addr = a;
      en   = 1'b1;
      wen  = 1'b0;
      @(posedge clk);
      #1;
      en = 1'b0;
   endtask

   function automatic void add_frame(input logic [7:0] b, input int div);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++)
         for (int c = 0; c < div; c++) exp_q.push_back(bits[k]);
   endfunction

   function automatic void add_idle(input int n);
      for (int c = 0; c < n; c++) exp_q.push_back(1'b1);
   endfunction

   // Steps n cycles, dropping any pending bus access after the first edge, and checks tx.
   task automatic run_wave(input int n);
      logic e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         en  = 1'b0;
         wen = 1'b0;
         e   = exp_q.pop_front();
         check("tx_wave", {31'b0, tx}, {31'b0, e});
      end
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      wen   = 1'b0;
      addr  = 32'b0;
      wdata = 32'b0;

      // Reset
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_tx", {31'b0, tx}, 32'd1);
      check("reset_rdata", rdata, 32'd0);
      check("reset_hit", {31'b0, hit}, 32'd0);
      rst = 1'b0;
      bus_read(BASE | 32'h4);
      check("reset_status", rdata, 32'h0000_0002);
      check("reset_status_hit", {31'b0, hit}, 32'd1);
      bus_read(BASE | 32'h8);
      check("reset_baud", rdata, 32'd434);

      // Single byte 0xA5 at divisor 4
      bus_write(4'h8, 32'd4);
      bus_write(4'h0, 32'h0000_00A5);
      add_frame(8'hA5, 4);
      add_idle(4);
      run_wave(exp_q.size());
      bus_read(BASE | 32'h4);
      check("single_status_idle", rdata, 32'h0000_0002);

      // Overflow: 10 pushes while the first frame is still in its start bit
      bus_write(4'h8, 32'd1000);
      for (int i = 0; i < 10; i++) bus_write(4'h0, 32'(i + 1));
      bus_read(BASE | 32'h4);
      check("ovf_status", rdata, 32'h0000_080D);
      bus_read(BASE | 32'h4);
      check("ovf_cleared", rdata, 32'h0000_0805);
      bus_read(BASE | 32'h0);
      check("txdata_read_zero", rdata, 32'd0);
      check("txdata_read_hit", {31'b0, hit}, 32'd1);
      bus_read(BASE | 32'h8);
      check("baud_1000", rdata, 32'd1000);
      bus_write(4'h8, 32'd0);
      bus_read(BASE | 32'h8);
      check("baud_zero_is_one", rdata, 32'd1);
      bus_read(BASE | 32'hC);
      check("unmapped_read", rdata, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_read(BASE | 32'h4);
      check("ovf_after_reset", rdata, 32'h0000_0002);

      // Back-to-back 0x00 then 0xFF at divisor 2
      bus_write(4'h8, 32'd2);
      bus_write(4'h0, 32'h0000_0000);
      set_write(4'h0, 32'h0000_00FF);
      add_frame(8'h00, 2);
      add_frame(8'hFF, 2);
      add_idle(4);
      run_wave(exp_q.size());

      // Baud change mid-frame: first frame at 4, second at 8
      bus_write(4'h8, 32'd4);
      bus_write(4'h0, 32'h0000_003C);
      set_write(4'h0, 32'h0000_0081);
      add_frame(8'h3C, 4);
      add_frame(8'h81, 8);
      add_idle(4);
      run_wave(10);
      set_write(4'h8, 32'd8);
      run_wave(exp_q.size());

      // Reset mid-frame, inside a zero data bit, with a second byte queued
      bus_write(4'h0, 32'h0000_0000);
      set_write(4'h0, 32'h0000_0000);
      add_frame(8'h00, 8);
      run_wave(12);
      exp_q.delete();
      bus_read(BASE | 32'h4);
      check("midframe_status", rdata, 32'h0000_0104);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midframe_reset_tx", {31'b0, tx}, 32'd1);
      rst = 1'b0;
      bus_read(BASE | 32'h4);
      check("midframe_reset_status", rdata, 32'h0000_0002);
      check("midframe_reset_hit", {31'b0, hit}, 32'd1);
      bus_read(BASE | 32'h8);
      check("midframe_reset_baud", rdata, 32'd434);

      // Address miss just above the window
      bus_read(BASE + 32'h10);
      check("miss_hit", {31'b0, hit}, 32'd0);
      check("miss_rdata", rdata, 32'd0);
      bus_write(4'h8, 32'd5);
      check("write_no_hit", {31'b0, hit}, 32'd0);
      check("write_rdata_zero", rdata, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the CPU's data-memory port and consumes its `addrout`/`dataout`/`wen`/`en` outputs. Writes to its address window push bytes into a small FIFO, which a 8N1 serial transmitter drains. Register reads return status and configuration on a registered read bus, which the system muxes into the CPU's `datain` using `hit`.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_FF00, base of the 16-byte register window; bits [3:0] must be zero.
- `FIFO_DEPTH`, 8, TX FIFO entries; a power of two from 2 to 16.
- `DEFAULT_DIV`, 16'd434, reset value of the baud divisor (clk cycles per bit).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  32  CPU data address (`addrout`).
- `wdata`  in  32  CPU write data (`dataout`).
- `en`  in  1  CPU memory access strobe.
- `wen`  in  1  1 = write, 0 = read; qualified by `en`.
- `rdata`  out  32  registered read data.
- `hit`  out  1  registered: the previous cycle's access decoded into this block.
- `tx`  out  1  serial output; idles high.

## Operation
- Decode: `sel = en && addr[31:4] == BASE_ADDR[31:4]`. Offset `addr[3:0]`:
  - 0x0 TXDATA: a write pushes `wdata[7:0]`; a read returns 0.
  - 0x4 STATUS: read-only. Bit0 = full, bit1 = empty, bit2 = busy (FSM not IDLE), bit3 = overflow (sticky), bits[12:8] = FIFO count, all others 0.
  - 0x8 BAUD: read/write `wdata[15:0]`; a write of 0 stores 1. A read returns the value zero-extended.
  - Other offsets: writes are ignored; reads return 0.
- Push to a full FIFO: the byte is dropped, contents are unchanged, and overflow is set.
  - A STATUS read returns overflow = 1 and then clears it.
  - If a set and a clear land in the same cycle, set wins.
- Push and pop in the same cycle: both happen and the count is unchanged. This includes the full case: the push is accepted because the pop frees a slot.
- Transmitter FSM: IDLE → START → DATA → STOP.
  - IDLE (`tx` = 1): if the FIFO is not empty, pop the head into an 8-bit shift register, latch BAUD into the working divisor, and go to START.
  - START (`tx` = 0): lasts one bit period, then go to DATA.
  - DATA: `tx` = shift[0], LSB first. After each bit period, shift right. After 8 bits, go to STOP.
  - STOP (`tx` = 1): lasts one bit period. At its end, if the FIFO is not empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
- Bit period = latched divisor cycles. A write to BAUD mid-frame does not affect the current frame; it applies from the next frame.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.

## Timing
- Reset values:
  - `tx` = 1, `rdata` = 0, `hit` = 0.
  - FIFO empty (count 0), overflow = 0, BAUD = DEFAULT_DIV, FSM = IDLE.
- Reset mid-frame: on the reset edge `tx` returns to 1 and the frame is abandoned with no stop bit. Queued bytes are discarded.
- Reads: `rdata` and `hit` are registered on the edge that samples `en`, so they are valid one cycle after the access.
  - If the access did not select this block, or was a write, `rdata` = 0 and `hit` = 0 on the next cycle.
- Writes take effect at the sampling edge. A STATUS read in the next cycle reflects them.
- Latency: a TXDATA write at edge E0 into an empty FIFO with the FSM idle causes the FIFO to be non-empty after E0. The FSM pops at E1, and `tx` falls at E1.
- A frame is exactly 10 × divisor cycles. Back-to-back frames have no gap between the stop bit and the next start bit.

## Test plan
- Reset: hold `rst` for 2 cycles. Required: `tx` = 1, `rdata` = 0, `hit` = 0, and a STATUS read returns 0x0000_0002 (empty).
- Single byte: BAUD = 4, write 0xA5 to TXDATA. Required: `tx` falls one edge later, then carries 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles (40 cycles total), then stays 1.
- Overflow: BAUD = 1000, then 10 consecutive TXDATA writes.
  - Required after the first pop: count = 8. The 10th write is dropped, and STATUS reads full = 1, overflow = 1.
  - A second STATUS read shows overflow = 0.
- Back-to-back: BAUD = 2, write 0x00 then 0xFF. Required: a 40-cycle `tx` waveform with the second start bit immediately after the first stop bit.
- Baud change mid-frame: BAUD = 4, send a byte, then write BAUD = 8 in the middle of the DATA state. Required: the current frame keeps 4-cycle bits and the next frame uses 8.
- Reset mid-frame and address miss:
  - Assert `rst` during DATA. Required: `tx` = 1 the next cycle and count = 0.
  - Read at `BASE_ADDR` + 0x10. Required: `hit` = 0 and `rdata` = 0.
